// File: rtl/mips_mc_pkg.sv
// Shared types and encodings for the multi-cycle MIPS-I subset core.
package mips_mc_pkg;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_HALT
    } state_e;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_SLT,
        ALU_SLL,
        ALU_SRL
    } alu_op_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [4:0] REG_RA = 5'd31;

    function automatic logic [31:0] sext16(input logic [15:0] imm);
        return {{16{imm[15]}}, imm};
    endfunction

endpackage

// File: rtl/mips_mc_regfile.sv
// 32x32 register file: two asynchronous read ports, one synchronous write port, $0 reads 0.
module mips_mc_regfile
    import mips_mc_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  ra1_i,
    input  logic [4:0]  ra2_i,
    output logic [31:0] rd1_o,
    output logic [31:0] rd2_o,
    input  logic        we_i,
    input  logic [4:0]  wa_i,
    input  logic [31:0] wd_i
);

    logic [31:0] regs_q [32];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i && (wa_i != '0)) begin
            regs_q[wa_i] <= wd_i;
        end
    end

    assign rd1_o = (ra1_i == '0) ? '0 : regs_q[ra1_i];
    assign rd2_o = (ra2_i == '0) ? '0 : regs_q[ra2_i];

endmodule

// File: rtl/mips_multicycle_core.sv
// Multi-cycle MIPS-I subset core with one shared req/ready memory port.
// Optional retire trace ports are enabled by defining MIPS_MC_TRACE_EN.
module mips_multicycle_core
    import mips_mc_pkg::*;
#(
    parameter int unsigned ADDR_W   = 16,
    parameter logic [31:0] RESET_PC = 32'h0,
    parameter int unsigned TIMEOUT  = 0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,
    output logic              halted
`ifdef MIPS_MC_TRACE_EN
    ,
    output logic              retire_valid,
    output logic [ADDR_W-1:0] retire_pc,
    output logic [4:0]        retire_rd,
    output logic [31:0]       retire_data
`endif
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d, target_q, target_d, addr_q, addr_d;
    logic [31:0]       ir_q, ir_d, a_q, a_d, b_q, b_d, alu_q, alu_d, mdr_q, mdr_d;
    logic [31:0]       wdata_q, wdata_d, wait_q, wait_d;
    logic              req_q, req_d, we_q, we_d;

    logic [5:0]  op, fn;
    logic [4:0]  rs, rt, rd, shamt;
    logic [31:0] imm_x, br_off, alu_b, alu_res, pc_x, jt;
    logic [31:0] rf_rd1, rf_rd2, rf_wd;
    logic [4:0]  rf_wa;
    logic        rf_we, legal, done, timeout;
    alu_op_e     alu_op;
    logic        unused_ok;

    assign op     = ir_q[31:26];
    assign rs     = ir_q[25:21];
    assign rt     = ir_q[20:16];
    assign rd     = ir_q[15:11];
    assign shamt  = ir_q[10:6];
    assign fn     = ir_q[5:0];
    assign imm_x  = sext16(ir_q[15:0]);
    assign br_off = imm_x << 2;
    assign pc_x   = 32'(pc_q);
    assign jt     = {pc_x[31:28], ir_q[25:0], 2'b00};
    assign done   = req_q && mem_ready;
    assign timeout = (TIMEOUT != 0) && req_q && !mem_ready && (wait_q >= 32'(TIMEOUT));
    assign unused_ok = ^{alu_res, jt, pc_x, br_off};

    mips_mc_regfile u_regfile (
        .clk   (clk),
        .rst   (rst),
        .ra1_i (rs),
        .ra2_i (rt),
        .rd1_o (rf_rd1),
        .rd2_o (rf_rd2),
        .we_i  (rf_we),
        .wa_i  (rf_wa),
        .wd_i  (rf_wd)
    );

    always_comb begin
        legal  = 1'b0;
        alu_op = ALU_ADD;
        case (op)
            OP_RTYPE: begin
                case (fn)
                    FN_ADD: begin legal = 1'b1; alu_op = ALU_ADD; end
                    FN_SUB: begin legal = 1'b1; alu_op = ALU_SUB; end
                    FN_AND: begin legal = 1'b1; alu_op = ALU_AND; end
                    FN_OR:  begin legal = 1'b1; alu_op = ALU_OR;  end
                    FN_SLT: begin legal = 1'b1; alu_op = ALU_SLT; end
                    FN_SLL: begin legal = 1'b1; alu_op = ALU_SLL; end
                    FN_SRL: begin legal = 1'b1; alu_op = ALU_SRL; end
                    FN_JR:  legal = 1'b1;
                    default: legal = 1'b0;
                endcase
            end
            OP_J, OP_JAL, OP_BEQ, OP_ADDI, OP_LW, OP_SW: legal = 1'b1;
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        alu_b = (op == OP_RTYPE) ? b_q : imm_x;
        case (alu_op)
            ALU_ADD: alu_res = a_q + alu_b;
            ALU_SUB: alu_res = a_q - alu_b;
            ALU_AND: alu_res = a_q & alu_b;
            ALU_OR:  alu_res = a_q | alu_b;
            ALU_SLT: alu_res = {31'b0, ($signed(a_q) < $signed(alu_b))};
            ALU_SLL: alu_res = alu_b << shamt;
            ALU_SRL: alu_res = alu_b >> shamt;
            default: alu_res = a_q + alu_b;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        a_d      = a_q;
        b_d      = b_q;
        target_d = target_q;
        alu_d    = alu_q;
        mdr_d    = mdr_q;
        req_d    = 1'b0;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        wait_d   = (req_q && !mem_ready) ? wait_q + 32'd1 : '0;
        rf_we    = 1'b0;
        rf_wa    = rd;
        rf_wd    = alu_q;
        case (state_q)
            ST_FETCH: begin
                if (done) begin
                    ir_d    = mem_rdata;
                    pc_d    = pc_q + ADDR_W'(32'd4);
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                a_d      = rf_rd1;
                b_d      = rf_rd2;
                target_d = pc_q + br_off[ADDR_W-1:0];
                state_d  = legal ? ST_EXEC : ST_HALT;
            end
            ST_EXEC: begin
                alu_d = alu_res;
                if (op == OP_BEQ) begin
                    if (a_q == b_q) pc_d = target_q;
                    state_d = ST_FETCH;
                end else if (op == OP_J || op == OP_JAL) begin
                    pc_d    = jt[ADDR_W-1:0];
                    state_d = ST_FETCH;
                    if (op == OP_JAL) begin
                        rf_we = 1'b1;
                        rf_wa = REG_RA;
                        rf_wd = pc_x;
                    end
                end else if (op == OP_RTYPE && fn == FN_JR) begin
                    pc_d    = a_q[ADDR_W-1:0];
                    state_d = (a_q[1:0] != 2'b00) ? ST_HALT : ST_FETCH;
                end else if (op == OP_LW || op == OP_SW) begin
                    if (alu_res[1:0] != 2'b00) begin
                        state_d = ST_HALT;
                    end else begin
                        state_d = ST_MEM;
                        req_d   = 1'b1;
                        we_d    = (op == OP_SW);
                        addr_d  = alu_res[ADDR_W-1:0];
                        wdata_d = b_q;
                    end
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_MEM: begin
                if (done) begin
                    mdr_d   = mem_rdata;
                    state_d = (op == OP_LW) ? ST_WB : ST_FETCH;
                end else begin
                    req_d = 1'b1;
                end
            end
            ST_WB: begin
                rf_we   = 1'b1;
                rf_wa   = (op == OP_RTYPE) ? rd : rt;
                rf_wd   = (op == OP_LW) ? mdr_q : alu_q;
                state_d = ST_FETCH;
            end
            default: state_d = ST_HALT;
        endcase
        if (timeout) state_d = ST_HALT;
        // The next fetch request is set up as the FSM enters FETCH so it is visible in the FETCH cycle.
        if (state_d == ST_FETCH) begin
            req_d  = 1'b1;
            we_d   = 1'b0;
            addr_d = pc_d;
        end else if (state_d == ST_HALT) begin
            req_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_FETCH;
            pc_q     <= RESET_PC[ADDR_W-1:0];
            ir_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            target_q <= '0;
            alu_q    <= '0;
            mdr_q    <= '0;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wait_q   <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            a_q      <= a_d;
            b_q      <= b_d;
            target_q <= target_d;
            alu_q    <= alu_d;
            mdr_q    <= mdr_d;
            req_q    <= req_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            wait_q   <= wait_d;
        end
    end

    assign mem_req   = req_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign halted    = (state_q == ST_HALT);

`ifdef MIPS_MC_TRACE_EN
    logic              ret_v_q, ret_v_d;
    logic [ADDR_W-1:0] ret_pc_q, ret_pc_d;
    logic [4:0]        ret_rd_q, ret_rd_d;
    logic [31:0]       ret_data_q, ret_data_d;

    always_comb begin
        ret_v_d    = (state_q == ST_EXEC || state_q == ST_MEM || state_q == ST_WB) &&
                     (state_d == ST_FETCH);
        ret_pc_d   = pc_q - ADDR_W'(32'd4);
        ret_rd_d   = (ret_v_d && rf_we) ? rf_wa : '0;
        ret_data_d = (ret_v_d && rf_we && rf_wa != '0) ? rf_wd : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ret_v_q    <= 1'b0;
            ret_pc_q   <= '0;
            ret_rd_q   <= '0;
            ret_data_q <= '0;
        end else begin
            ret_v_q    <= ret_v_d;
            ret_pc_q   <= ret_pc_d;
            ret_rd_q   <= ret_rd_d;
            ret_data_q <= ret_data_d;
        end
    end

    assign retire_valid = ret_v_q;
    assign retire_pc    = ret_pc_q;
    assign retire_rd    = ret_rd_q;
    assign retire_data  = ret_data_q;
`endif

endmodule

// File: tb/tb_mips_multicycle_core.sv
// Directed bench for mips_multicycle_core: program vectors plus multi-cycle corner sequences.
module tb_mips_multicycle_core;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_req, mem_we, mem_ready, halted;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata;

    mips_multicycle_core #(.ADDR_W(16), .RESET_PC(32'h40), .TIMEOUT(0)) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .halted    (halted)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [1024];
    logic [15:0] stall_addr = 16'hFFFF;
    int          stall_n = 0;
    int          stall_cnt = 0;
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;

    typedef struct {
        int          cyc;
        logic [15:0] addr;
        logic        we;
        logic [31:0] wdata;
    } tr_t;
    tr_t log_q[$];

    assign mem_ready = mem_req && ((mem_addr != stall_addr) || (stall_cnt >= stall_n));
    assign mem_rdata = mem[mem_addr[11:2]];

    always @(posedge clk) begin
        cyc       <= cyc + 1;
        stall_cnt <= (mem_req && !mem_ready) ? stall_cnt + 1 : 0;
        if (!rst && mem_req && mem_ready)
            log_q.push_back('{cyc: cyc, addr: mem_addr, we: mem_we, wdata: mem_wdata});
    end

    typedef struct {
        logic [5:0][31:0] p;
        int               n;
        logic [31:0]      exp;
        int               exp_cyc;
    } vec_t;

    function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input int sh, input int fn);
        return {6'h00, rs[4:0], rt[4:0], rd[4:0], sh[4:0], fn[5:0]};
    endfunction

    function automatic logic [31:0] enc_i(input int op, input int rs, input int rt, input int imm);
        return {op[5:0], rs[4:0], rt[4:0], imm[15:0]};
    endfunction

    function automatic logic [31:0] enc_j(input int op, input int idx);
        return {op[5:0], idx[25:0]};
    endfunction

    function automatic vec_t mk(input logic [31:0] i0, input logic [31:0] i1, input logic [31:0] i2,
                                input logic [31:0] i3, input logic [31:0] i4, input int n,
                                input logic [31:0] e, input int ec);
        vec_t v;
        v.p    = '0;
        v.p[0] = i0; v.p[1] = i1; v.p[2] = i2; v.p[3] = i3; v.p[4] = i4;
        v.n = n; v.exp = e; v.exp_cyc = ec;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        mem[32'h210 >> 2] = 32'hDEADBEEF;
    endtask

    task automatic load_vec(input vec_t v);
        clear_mem();
        for (int i = 0; i < v.n; i++) mem[(32'h40 >> 2) + i] = v.p[i];
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        log_q.delete();
    endtask

    task automatic run_store(input int maxc, output int si);
        si = -1;
        for (int c = 0; c < maxc && si < 0; c++) begin
            @(negedge clk);
            foreach (log_q[k]) if (log_q[k].we && si < 0) si = k;
        end
    endtask

    task automatic wait_req_at(input logic [15:0] a, input int maxc, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < maxc && !ok; c++) begin
            @(negedge clk);
            if (mem_req && mem_addr == a) ok = 1'b1;
        end
    endtask

    localparam int SW3 = 32'hAC030100;  // sw $3,0x100($0)

    vec_t vt [13];
    vec_t ht [5];

    initial begin
        int  si, hc, n0;
        bit  ok;

        vt[0]  = mk(enc_i(8,0,1,5), enc_i(8,0,2,7), enc_r(1,2,3,0,32'h20), SW3, 0, 4, 32'd12, 15);
        vt[1]  = mk(enc_i(8,0,1,3), enc_i(8,0,2,10), enc_r(1,2,3,0,32'h22), SW3, 0, 4, 32'hFFFFFFF9, 15);
        vt[2]  = mk(enc_i(8,0,1,32'h0F0F), enc_i(8,0,2,32'hFF), enc_r(1,2,3,0,32'h24), SW3, 0, 4, 32'h0000000F, 15);
        vt[3]  = mk(enc_i(8,0,1,32'h0F0F), enc_i(8,0,2,32'hFF), enc_r(1,2,3,0,32'h25), SW3, 0, 4, 32'h00000FFF, 15);
        vt[4]  = mk(enc_i(8,0,1,-1), enc_i(8,0,2,1), enc_r(1,2,3,0,32'h2A), SW3, 0, 4, 32'd1, 15);
        vt[5]  = mk(enc_i(8,0,1,-1), enc_i(8,0,2,1), enc_r(2,1,3,0,32'h2A), SW3, 0, 4, 32'd0, 15);
        vt[6]  = mk(enc_i(8,0,1,3), enc_r(0,1,3,4,0), SW3, 0, 0, 3, 32'h30, 11);
        vt[7]  = mk(enc_i(8,0,1,-16), enc_r(0,1,3,4,2), SW3, 0, 0, 3, 32'h0FFFFFFF, 11);
        vt[8]  = mk(enc_i(8,0,0,9), enc_r(0,0,3,0,32'h20), SW3, 0, 0, 3, 32'd0, 11);
        vt[9]  = mk(enc_i(8,0,1,32'h7FFF), enc_r(0,1,1,16,0), enc_r(1,1,3,0,32'h20), SW3, 0, 4, 32'hFFFE0000, 15);
        vt[10] = mk(enc_i(32'h23,0,3,32'h210), SW3, 0, 0, 0, 2, 32'hDEADBEEF, 8);
        vt[11] = mk(enc_i(8,0,1,1), enc_i(4,1,0,1), enc_i(8,0,3,5), SW3, 0, 4, 32'd5, 14);
        vt[12] = mk(enc_i(8,0,1,1), enc_i(8,0,2,1), enc_i(4,1,2,1), enc_i(8,0,3,5), SW3, 5, 32'd0, 14);

        // exp = transactions before halt, exp_cyc = halt cycle relative to first fetch
        ht[0] = mk(enc_i(32'h23,0,3,32'h102), 0, 0, 0, 0, 1, 32'd1, 3);
        ht[1] = mk(32'hFC000000, 0, 0, 0, 0, 1, 32'd1, 2);
        ht[2] = mk(enc_r(0,0,0,0,32'h3F), 0, 0, 0, 0, 1, 32'd1, 2);
        ht[3] = mk(enc_i(32'h2B,0,0,32'h101), 0, 0, 0, 0, 1, 32'd1, 3);
        ht[4] = mk(enc_i(8,0,1,32'h41), enc_r(1,0,0,0,8), 0, 0, 0, 2, 32'd2, 7);

        // Reset state and first fetch at RESET_PC.
        clear_mem();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_req", {31'b0, mem_req}, 32'd0);
        chk("rst_we", {31'b0, mem_we}, 32'd0);
        chk("rst_addr", {16'b0, mem_addr}, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_halted", {31'b0, halted}, 32'd0);
        rst = 1'b0;
        wait_req_at(16'h40, 10, ok);
        chk("first_fetch_seen", {31'b0, ok}, 32'd1);
        chk("first_fetch_we", {31'b0, mem_we}, 32'd0);

        // Program vectors, each ending in a store of the result.
        for (int v = 0; v < 13; v++) begin
            load_vec(vt[v]);
            do_reset();
            run_store(200, si);
            chk($sformatf("vec%0d_store_seen", v), (si >= 0) ? 32'd1 : 32'd0, 32'd1);
            if (si >= 0) begin
                chk($sformatf("vec%0d_addr", v), {16'b0, log_q[si].addr}, 32'h100);
                chk($sformatf("vec%0d_data", v), log_q[si].wdata, vt[v].exp);
                chk($sformatf("vec%0d_cycles", v), log_q[si].cyc - log_q[0].cyc, vt[v].exp_cyc);
            end
        end

        // lw with three wait cycles: request held stable, load result forwarded to a store.
        clear_mem();
        mem[16] = enc_i(32'h23,0,3,32'h210);
        mem[17] = SW3;
        stall_addr = 16'h210;
        stall_n    = 3;
        do_reset();
        wait_req_at(16'h210, 40, ok);
        chk("lw_req_seen", {31'b0, ok}, 32'd1);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("lw_hold%0d_addr", k), {16'b0, mem_addr}, 32'h210);
            chk($sformatf("lw_hold%0d_req_we", k), {30'b0, mem_req, mem_we}, 32'd2);
            chk($sformatf("lw_hold%0d_ready", k), {31'b0, mem_ready}, (k == 3) ? 32'd1 : 32'd0);
            @(negedge clk);
        end
        run_store(60, si);
        chk("lw_wait_store_seen", (si >= 0) ? 32'd1 : 32'd0, 32'd1);
        if (si >= 0) begin
            chk("lw_wait_data", log_q[si].wdata, 32'hDEADBEEF);
            chk("lw_wait_cycles", log_q[si].cyc - log_q[0].cyc, 32'd11);
        end
        stall_addr = 16'hFFFF;
        stall_n    = 0;

        // beq $1,$1,-1 loops on itself every three cycles.
        clear_mem();
        mem[16] = enc_i(4,1,1,-1);
        do_reset();
        for (int c = 0; c < 40 && log_q.size() < 3; c++) @(negedge clk);
        chk("beq_loop_count", (log_q.size() >= 3) ? 32'd1 : 32'd0, 32'd1);
        if (log_q.size() >= 3) begin
            chk("beq_loop_addr1", {16'b0, log_q[1].addr}, 32'h40);
            chk("beq_loop_addr2", {16'b0, log_q[2].addr}, 32'h40);
            chk("beq_loop_period", log_q[1].cyc - log_q[0].cyc, 32'd3);
        end

        // j 0x20; jal 0x30 at 0x20; jr $31 at 0x30; sw $31 at 0x24.
        clear_mem();
        mem[16] = enc_j(2, 8);
        mem[8]  = enc_j(3, 12);
        mem[9]  = enc_i(32'h2B,0,31,32'h100);
        mem[12] = enc_r(31,0,0,0,8);
        do_reset();
        run_store(80, si);
        chk("jal_store_seen", (si >= 0) ? 32'd1 : 32'd0, 32'd1);
        if (si == 4) begin
            chk("jal_fetch_target", {16'b0, log_q[2].addr}, 32'h30);
            chk("jr_fetch_target", {16'b0, log_q[3].addr}, 32'h24);
            chk("jal_ra_value", log_q[4].wdata, 32'h24);
        end else begin
            chk("jal_store_index", si, 32'd4);
        end

        // Halt conditions: no request issued, halted is absorbing.
        for (int h = 0; h < 5; h++) begin
            load_vec(ht[h]);
            do_reset();
            hc = -1;
            for (int c = 0; c < 60 && hc < 0; c++) begin
                @(negedge clk);
                if (halted) hc = cyc;
            end
            chk($sformatf("halt%0d_seen", h), (hc >= 0) ? 32'd1 : 32'd0, 32'd1);
            if (hc >= 0 && log_q.size() > 0) begin
                chk($sformatf("halt%0d_cycle", h), hc - log_q[0].cyc, ht[h].exp_cyc);
                n0 = log_q.size();
                chk($sformatf("halt%0d_accesses", h), n0, ht[h].exp);
                repeat (10) @(negedge clk);
                chk($sformatf("halt%0d_sticky", h), {30'b0, halted, mem_req}, 32'd2);
                chk($sformatf("halt%0d_no_new_access", h), log_q.size(), n0);
            end
        end

        // Reset while a store waits on mem_ready.
        clear_mem();
        mem[16] = enc_i(8,0,1,32'h55);
        mem[17] = enc_i(32'h2B,0,1,32'h180);
        stall_addr = 16'h180;
        stall_n    = 1000;
        do_reset();
        wait_req_at(16'h180, 40, ok);
        chk("rst_store_pending", {31'b0, ok}, 32'd1);
        chk("rst_store_wdata", mem_wdata, 32'h55);
        chk("rst_store_we", {31'b0, mem_we}, 32'd1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_req_drop", {31'b0, mem_req}, 32'd0);
        rst = 1'b0;
        n0 = 0;
        foreach (log_q[k]) if (log_q[k].we) n0++;
        chk("rst_mid_no_write", n0, 32'd0);
        log_q.delete();
        for (int c = 0; c < 10 && log_q.size() == 0; c++) @(negedge clk);
        chk("rst_mid_refetch_seen", (log_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
        if (log_q.size() > 0) begin
            chk("rst_mid_refetch_addr", {16'b0, log_q[0].addr}, 32'h40);
            chk("rst_mid_refetch_we", {31'b0, log_q[0].we}, 32'd0);
        end
        stall_addr = 16'hFFFF;
        stall_n    = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
